// File: rtl/ascon_pkg.sv
// Shared types and S-box tables for the ASCON S-box datapath.
// ASCON_SBOX_INV_EN adds the inverse table.
package ascon_pkg;

  localparam int unsigned NUM_WORDS  = 5;
  localparam int unsigned WORD_WIDTH = 64;

  // Word 0 is x0, the MSB of every 5-bit column index.
  typedef logic [NUM_WORDS-1:0][WORD_WIDTH-1:0] ascon_state_t;

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

`ifdef ASCON_SBOX_INV_EN
  localparam logic [4:0] SBOX_INV [32] = '{
    5'h14, 5'h1a, 5'h07, 5'h0d, 5'h00, 5'h09, 5'h0e, 5'h12,
    5'h0a, 5'h06, 5'h1d, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1e,
    5'h18, 5'h16, 5'h0b, 5'h11, 5'h03, 5'h05, 5'h1c, 5'h1f,
    5'h17, 5'h1b, 5'h04, 5'h08, 5'h0f, 5'h0c, 5'h10, 5'h02
  };
`endif

endpackage

// File: rtl/ascon_sbox5.sv
// Combinational 5-bit ASCON S-box lookup; the inverse table exists only
// when ASCON_SBOX_INV_EN is defined, otherwise inv is ignored.
module ascon_sbox5
  import ascon_pkg::*;
(
  input  logic [4:0] x,
  input  logic       inv,
  output logic [4:0] y
);

`ifdef ASCON_SBOX_INV_EN
  assign y = inv ? SBOX_INV[x] : SBOX[x];
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign y = SBOX[x];
`endif

endmodule

// File: rtl/ascon_sbox_folded.sv
// Folded ASCON S-box layer: SLICES columns of the 320-bit state per cycle,
// valid/ready on both sides. ASCON_SBOX_INV_EN enables the inverse mode.
module ascon_sbox_folded
  import ascon_pkg::*;
#(
  parameter int unsigned SLICES = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  output logic         ready_o,
  input  ascon_state_t state_i,
  input  logic         inv_i,
  output logic         valid_o,
  input  logic         ready_i,
  output ascon_state_t state_o,
  output logic         busy_o
);

  localparam int unsigned N     = WORD_WIDTH / SLICES;
  localparam int unsigned CW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SHIFT = $clog2(SLICES);
  localparam int unsigned IW    = $clog2(WORD_WIDTH);

  if ((SLICES != 1) && (SLICES != 2) && (SLICES != 4) && (SLICES != 8) &&
      (SLICES != 16) && (SLICES != 32) && (SLICES != 64)) begin : g_bad_slices
    $error("ascon_sbox_folded: illegal SLICES value %0d", SLICES);
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  fsm_e                   fsm_q;
  logic [CW-1:0]          cnt_q;
  logic                   inv_q;
  logic [IW-1:0]          base_c;
  logic [SLICES-1:0][4:0] col_c;
  logic [SLICES-1:0][4:0] sub_c;
  ascon_state_t           st_run_c;

  // First column handled in the current pass.
  assign base_c = IW'(cnt_q) << SHIFT;

  always_comb begin
    col_c = '0;
    for (int s = 0; s < SLICES; s++) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        col_c[s][4-w] = state_o[w][base_c + IW'(s)];
      end
    end
  end

  for (genvar g = 0; g < SLICES; g++) begin : g_sbox
    ascon_sbox5 u_sbox (
      .x  (col_c[g]),
      .inv(inv_q),
      .y  (sub_c[g])
    );
  end

  // Working register with the current pass's columns substituted.
  always_comb begin
    st_run_c = state_o;
    for (int s = 0; s < SLICES; s++) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        st_run_c[w][base_c + IW'(s)] = sub_c[s][4-w];
      end
    end
  end

`ifdef ASCON_SBOX_INV_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inv_q <= 1'b0;
    end else if ((fsm_q == IDLE) && valid_i && ready_o) begin
      inv_q <= inv_i;
    end
  end
`else
  logic unused_inv_i;
  assign unused_inv_i = inv_i;
  assign inv_q        = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm_q   <= IDLE;
      cnt_q   <= '0;
      state_o <= '0;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (valid_i && ready_o) begin
            fsm_q   <= RUN;
            cnt_q   <= '0;
            state_o <= state_i;
            ready_o <= 1'b0;
            busy_o  <= 1'b1;
          end
        end
        RUN: begin
          state_o <= st_run_c;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            fsm_q   <= DONE;
            valid_o <= 1'b1;
          end
        end
        DONE: begin
          if (valid_o && ready_i) begin
            fsm_q   <= IDLE;
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          fsm_q   <= IDLE;
          ready_o <= 1'b1;
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_sbox_folded.sv
// Bench for ascon_sbox_folded: four instances (SLICES 64, 4, 1, 8) checked
// against a column-wise table model; inverse checks need ASCON_SBOX_INV_EN.
module tb_ascon_sbox_folded;
  import ascon_pkg::*;

  localparam int NU = 4;
  localparam int unsigned SL [NU] = '{64, 4, 1, 8};

`ifdef ASCON_SBOX_INV_EN
  localparam bit INV_ON = 1'b1;
`else
  localparam bit INV_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic         vld_i [NU];
  logic         rdy_o [NU];
  ascon_state_t st_i  [NU];
  logic         inv_i [NU];
  logic         vld_o [NU];
  logic         rdy_i [NU];
  ascon_state_t st_o  [NU];
  logic         busy  [NU];

  for (genvar g = 0; g < NU; g++) begin : g_dut
    ascon_sbox_folded #(.SLICES(SL[g])) u_dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .valid_i(vld_i[g]),
      .ready_o(rdy_o[g]),
      .state_i(st_i[g]),
      .inv_i  (inv_i[g]),
      .valid_o(vld_o[g]),
      .ready_i(rdy_i[g]),
      .state_o(st_o[g]),
      .busy_o (busy[g])
    );
  end

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Independent copy of the ASCON S-box; the inverse is derived from it.
  logic [4:0] fwd_t [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };
  logic [4:0] inv_t [32];

  function automatic ascon_state_t model(input ascon_state_t s, input bit inv);
    ascon_state_t r;
    logic [4:0] c;
    logic [4:0] v;
    r = '0;
    for (int j = 0; j < 64; j++) begin
      c = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
      v = (inv && INV_ON) ? inv_t[c] : fwd_t[c];
      for (int w = 0; w < 5; w++) r[w][j] = v[4-w];
    end
    return r;
  endfunction

  function automatic ascon_state_t rnd_state();
    ascon_state_t s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic chk(input string nm, input logic [323:0] act, input logic [323:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction with ready_i high; lat = cycles from accept to valid_o.
  task automatic run_one(input int u, input ascon_state_t s, input bit inv,
                         output ascon_state_t r, output int lat);
    int n;
    rdy_i[u] = 1'b1;
    n = 0;
    while (!rdy_o[u] && n < 200) begin tick(); n++; end
    st_i[u] = s; inv_i[u] = inv; vld_i[u] = 1'b1;
    tick();
    vld_i[u] = 1'b0;
    inv_i[u] = 1'b0;
    lat = 0;
    while (!vld_o[u] && lat < 200) begin tick(); lat++; end
    r = st_o[u];
    tick();
  endtask

  typedef struct {
    int           u;
    ascon_state_t st;
    bit           inv;
    ascon_state_t exp;
    int           lat;
  } vec_t;

  vec_t         vecs [4];
  ascon_state_t s, r, r2, e, snap;
  int           lat, n;

  initial begin
    for (int i = 0; i < 32; i++) inv_t[fwd_t[i]] = 5'(i);
    for (int u = 0; u < NU; u++) begin
      vld_i[u] = 1'b0; st_i[u] = '0; inv_i[u] = 1'b0; rdy_i[u] = 1'b1;
    end

    // Directed vectors with hand-derived results.
    e = '0; e[2] = '1;
    vecs[0] = '{0, '0, 1'b0, e, 1};
    s = '1; e = '1; e[1] = '0;
    vecs[1] = '{1, s, 1'b0, e, 16};
    if (INV_ON) begin e = '0; e[0] = '1; e[2] = '1; end
    else        begin e = '0; e[2] = '1; end
    vecs[2] = '{0, '0, 1'b1, e, 1};
    if (INV_ON) begin e = '0; e[3] = '1; end
    else        begin e = '1; e[1] = '0; end
    vecs[3] = '{3, s, 1'b1, e, 8};

    #12 rst_n = 1'b1;
    tick();
    for (int u = 0; u < NU; u++)
      chk($sformatf("reset_u%0d", u), {rdy_o[u], vld_o[u], busy[u], st_o[u]},
          {1'b1, 1'b0, 1'b0, 320'd0});

    foreach (vecs[i]) begin
      run_one(vecs[i].u, vecs[i].st, vecs[i].inv, r, lat);
      chk($sformatf("vec%0d_result", i), r, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    // busy_o spans the 16 RUN cycles and the DONE cycle at SLICES=4.
    while (!rdy_o[1]) tick();
    st_i[1] = '1; vld_i[1] = 1'b1;
    tick();
    vld_i[1] = 1'b0;
    n = 0;
    while (busy[1] && n < 100) begin n++; tick(); end
    chk("busy_span", n, 17);
    chk("ready_after_busy", rdy_o[1], 1'b1);

    // Randomised forward/inverse requests on every instance.
    for (int u = 0; u < NU; u++) begin
      for (int k = 0; k < 30; k++) begin
        s = rnd_state();
        n = int'($urandom_range(0, 1));
        run_one(u, s, n[0], r, lat);
        chk($sformatf("rand_u%0d_%0d", u, k), r, model(s, n[0]));
        chk($sformatf("rand_lat_u%0d_%0d", u, k), lat, int'(64 / SL[u]));
      end
    end

`ifdef ASCON_SBOX_INV_EN
    // Forward then inverse must return the original state.
    for (int k = 0; k < 1000; k++) begin
      s = rnd_state();
      run_one(3, s, 1'b0, r, lat);
      chk($sformatf("rt_fwd_%0d", k), r, model(s, 1'b0));
      run_one(3, r, 1'b1, r2, lat);
      chk($sformatf("rt_inv_%0d", k), r2, s);
    end
`else
    for (int k = 0; k < 100; k++) begin
      s = rnd_state();
      run_one(3, s, 1'b1, r, lat);
      chk($sformatf("noinv_%0d", k), r, model(s, 1'b0));
    end
`endif

    // Back-pressure in DONE with ignored valid_i pulses.
    s = rnd_state();
    while (!rdy_o[1]) tick();
    rdy_i[1] = 1'b0;
    st_i[1] = s; vld_i[1] = 1'b1;
    tick();
    vld_i[1] = 1'b0;
    n = 0;
    while (!vld_o[1] && n < 200) begin tick(); n++; end
    snap = st_o[1];
    chk("bp_result", snap, model(s, 1'b0));
    for (int c = 0; c < 20; c++) begin
      vld_i[1] = c[0];
      st_i[1] = rnd_state();
      tick();
      chk($sformatf("bp_hold_%0d", c), {vld_o[1], rdy_o[1], busy[1], st_o[1]},
          {1'b1, 1'b0, 1'b1, snap});
    end
    vld_i[1] = 1'b0;
    rdy_i[1] = 1'b1;
    tick();
    chk("bp_release", {rdy_o[1], vld_o[1], busy[1]}, {1'b1, 1'b0, 1'b0});

    // Asynchronous reset 30 cycles into a 64-cycle run.
    while (!rdy_o[2]) tick();
    st_i[2] = rnd_state(); vld_i[2] = 1'b1;
    tick();
    vld_i[2] = 1'b0;
    repeat (30) tick();
    chk("midrun_busy", busy[2], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_reset", {rdy_o[2], vld_o[2], busy[2], st_o[2]},
        {1'b1, 1'b0, 1'b0, 320'd0});
    #2 rst_n = 1'b1;
    tick();
    s = rnd_state();
    run_one(2, s, 1'b0, r, lat);
    chk("post_reset_result", r, model(s, 1'b0));
    chk("post_reset_latency", lat, 64);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
